// File: rtl/cache_wr_back_handler.sv
// -----------------------------------------------------------------------------
// cache_wr_back_handler
//
// Write-back engine for dirty D-cache line evictions. One evicted line
// (WORDS x 32-bit words) is captured in a single cycle. It is then sent to L2
// as WORDS word writes using a ready/valid handshake. A one-cycle completion
// pulse follows the last accepted word. A combinational line-address hazard
// check lets the read-miss path stall while a matching line is still in flight.
//
// Ports
//   clk          : clock; all state updates on the rising edge
//   rst_n        : synchronous reset, active-low
//   wb_req       : eviction request; wb_tag / wb_index / wb_line valid while high
//   wb_tag       : tag of the evicted line (addr[31:14])
//   wb_index     : set index of the evicted line (addr[13:5])
//   wb_line      : line data; word i = wb_line[32*i+31:32*i]
//   wb_ack       : one-cycle pulse, line captured (first WRITE cycle)
//   wb_busy      : high whenever the engine is not idle
//   wb_done      : one-cycle pulse after L2 accepts the last word
//   l2_wr_en     : word write valid
//   l2_wr_addr   : L2 word address = {pad, tag, index, word_cnt}
//   l2_wr_data   : buffered word selected by word_cnt
//   l2_wr_ready  : L2 accepts the word when l2_wr_en & l2_wr_ready at a posedge
//   rd_chk_addr  : byte address of a pending read miss
//   rd_chk_hit   : combinational; busy and read-miss line matches buffered line
// -----------------------------------------------------------------------------
module cache_wr_back_handler #(
    parameter int TAG_W = 18,
    parameter int IDX_W = 9,
    parameter int WORDS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_req,
    input  logic [TAG_W-1:0]      wb_tag,
    input  logic [IDX_W-1:0]      wb_index,
    input  logic [WORDS*32-1:0]   wb_line,
    output logic                  wb_ack,
    output logic                  wb_busy,
    output logic                  wb_done,
    output logic                  l2_wr_en,
    output logic [31:0]           l2_wr_addr,
    output logic [31:0]           l2_wr_data,
    input  logic                  l2_wr_ready,
    input  logic [31:0]           rd_chk_addr,
    output logic                  rd_chk_hit
);

    localparam int CNT_W  = $clog2(WORDS);
    localparam int PAD_W  = 32 - TAG_W - IDX_W - CNT_W;
    localparam int LINE_W = WORDS * 32;
    localparam int LA_W   = TAG_W + IDX_W;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Select one 32-bit word out of the buffered line.
    function automatic logic [31:0] word_sel(input logic [LINE_W-1:0] line,
                                             input logic [CNT_W-1:0]  sel);
        return line[{sel, 5'b00000} +: 32];
    endfunction

    // Build the word-granular L2 address from tag, index and word number.
    function automatic logic [31:0] addr_make(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx,
                                              input logic [CNT_W-1:0] cnt);
        return {{PAD_W{1'b0}}, tag, idx, cnt};
    endfunction

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [TAG_W-1:0]    tag_q,   tag_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [LINE_W-1:0]   line_q,  line_d;
    logic                ack_q,   ack_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;
    logic                en_q,    en_d;
    logic [31:0]         addr_q,  addr_d;
    logic [31:0]         data_q,  data_d;

    // Low byte-offset bits of the read-miss address take no part in the line compare.
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = &{1'b0, rd_chk_addr[31-LA_W:0]};

    // Next-state, buffer capture and next-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        line_d  = line_q;
        ack_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wb_req) begin
                    tag_d   = wb_tag;
                    idx_d   = wb_index;
                    line_d  = wb_line;
                    cnt_d   = {CNT_W{1'b0}};
                    ack_d   = 1'b1;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // Without ready the counter holds, so address and data stay stable.
                if (l2_wr_ready) begin
                    if (cnt_q == LAST_WORD) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DONE: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d = (state_d != ST_IDLE);
        en_d   = (state_d == ST_WRITE);
        done_d = (state_d == ST_DONE);
        addr_d = addr_make(tag_d, idx_d, cnt_d);
        data_d = word_sel(line_d, cnt_d);
    end

    // State, buffers and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            tag_q   <= {TAG_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            line_q  <= {LINE_W{1'b0}};
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            data_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            line_q  <= line_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign wb_ack     = ack_q;
    assign wb_busy    = busy_q;
    assign wb_done    = done_q;
    assign l2_wr_en   = en_q;
    assign l2_wr_addr = addr_q;
    assign l2_wr_data = data_q;

    // Hazard: the buffered line stays visible through DONE; a capture cycle is
    // still idle, so it does not raise the hit until WRITE.
    assign rd_chk_hit = busy_q & (rd_chk_addr[31 -: LA_W] == {tag_q, idx_q});

endmodule
